clk_div_ctrl: RTL and testbench

- Run-time programmable clock-enable scheduler for the divider chain.
- Generates a one-cycle `tick` every N system clocks, plus a registered divided clock `clk_out`.
- Feeds the `en` inputs of the D-type flip-flop stages; those stages advance only on `tick`.
- Handles start/stop sequencing and glitch-free divisor changes at period boundaries.

---
 rtl/clk_div_ctrl.sv | 153 +++++++++++++++
 tb/tb_clk_div_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time programmable clock-enable scheduler for the divider chain. It
// produces a one-cycle `tick` every div_cur system clocks and a registered
// divided clock `clk_out`. Start/stop sequencing is graceful: a stop request
// lets the current period finish with its tick. Divisor changes made while
// running take effect only at a period boundary, so a period never mixes
// two divisors.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   level, requests running
//   stop      in   level, requests a stop at the end of the current period
//   div_load  in   one-cycle strobe, captures div_in (values 0/1 clamp to 2)
//   div_in    in   requested divisor
//   busy      out  high in RUN or STOPPING (decoded from state)
//   tick      out  one-cycle enable pulse per period (decoded from registers)
//   clk_out   out  registered divided clock, high phase first
//   div_cur   out  divisor currently in effect
//   load_ack  out  one-cycle pulse the cycle after a divisor is applied
// ----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             busy,
  output logic             tick,
  output logic             clk_out,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_ack
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             load_ack_q, load_ack_d;

  logic             tick_c;
  logic [WIDTH-1:0] div_clamped_c;

  // Divisors below 2 would make the period/compare meaningless; clamp them.
  assign div_clamped_c = (div_in < DIV_MIN) ? DIV_MIN : div_in;

  // End of period: last count of the current divisor while active.
  // div_cur_q >= 2 always, so the subtraction cannot underflow.
  assign tick_c = (state_q != S_IDLE) && (cnt_q == (div_cur_q - WIDTH'(1)));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      div_cur_q    <= DIV_RST;
      pend_div_q   <= DIV_RST;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_cur_q    <= div_cur_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      load_ack_q   <= load_ack_d;
    end
  end

  // Next-state logic for start/stop sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // start together with stop is treated as "not requested".
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        // A stop on the final cycle of a period needs no STOPPING detour.
        if (stop) state_d = tick_c ? S_IDLE : S_STOPPING;
      end
      S_STOPPING: begin
        if (tick_c)                state_d = S_IDLE;
        else if (start && !stop)   state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, divisor staging, divided clock and load acknowledge.
  always_comb begin
    cnt_d        = cnt_q;
    div_cur_d    = div_cur_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    load_ack_d   = 1'b0;
    clk_out_d    = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      // No period in flight: a load takes effect at once, including on the
      // edge that starts running, so the first period uses it.
      if (div_load) begin
        div_cur_d  = div_clamped_c;
        load_ack_d = 1'b1;
      end
    end else begin
      cnt_d = tick_c ? '0 : (cnt_q + WIDTH'(1));
      // Boundary: promote the staged divisor for the period starting now.
      if (tick_c && pend_valid_q) begin
        div_cur_d    = pend_div_q;
        pend_valid_d = 1'b0;
        load_ack_d   = 1'b1;
      end
      // A load on the boundary edge is staged for the following boundary;
      // the value promoted above is the older one.
      if (div_load) begin
        pend_div_d   = div_clamped_c;
        pend_valid_d = 1'b1;
      end
    end

    // High phase first; for odd divisors the high phase is the shorter one.
    if (state_d != S_IDLE) begin
      clk_out_d = (cnt_d < (div_cur_d >> 1));
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign tick     = tick_c;
  assign clk_out  = clk_out_q;
  assign div_cur  = div_cur_q;
  assign load_ack = load_ack_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             div_load;
  logic [WIDTH-1:0] div_in;
  logic             busy;
  logic             tick;
  logic             clk_out;
  logic [WIDTH-1:0] div_cur;
  logic             load_ack;

  int n_checks;
  int n_fail;

  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .div_load (div_load),
    .div_in   (div_in),
    .busy     (busy),
    .tick     (tick),
    .clk_out  (clk_out),
    .div_cur  (div_cur),
    .load_ack (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a stop and wait (bounded) for the block to return to IDLE.
  task automatic go_idle();
    int guard;
    start = 1'b0;
    stop  = 1'b1;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL go_idle timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_load = 1'b0; div_in = '0;
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset tick: got %b want 0", tick); end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset clk_out: got %b want 0", clk_out); end
    n_checks++; if (div_cur !== 16'd2) begin n_fail++; $display("FAIL reset div_cur: got %0d want 2", div_cur); end
    n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL reset load_ack: got %b want 0", load_ack); end
    rst = 1'b0;
  endtask

  // Default divisor 2: tick every other cycle, clk_out alternates 1,0.
  task automatic test_default_div();
    start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div2 busy i=%0d: got %b want 1", i, busy); end
      n_checks++; if (tick !== ((i % 2) == 1)) begin n_fail++; $display("FAIL div2 tick i=%0d: got %b want %b", i, tick, (i % 2) == 1); end
      n_checks++; if (clk_out !== ((i % 2) == 0)) begin n_fail++; $display("FAIL div2 clk_out i=%0d: got %b want %b", i, clk_out, (i % 2) == 0); end
      step();
    end
    go_idle();
  endtask

  // Load 5 in IDLE, then run: 2 high / 3 low, tick on the 5th cycle.
  task automatic test_idle_load();
    div_in = 16'd5; div_load = 1'b1;
    step();
    div_load = 1'b0;
    n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL idle_load ack: got %b want 1", load_ack); end
    n_checks++; if (div_cur !== 16'd5) begin n_fail++; $display("FAIL idle_load div_cur: got %0d want 5", div_cur); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_load busy: got %b want 0", busy); end
    step();
    n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL idle_load ack_drop: got %b want 0", load_ack); end
    start = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (tick !== ((i % 5) == 4)) begin n_fail++; $display("FAIL div5 tick i=%0d: got %b want %b", i, tick, (i % 5) == 4); end
      n_checks++; if (clk_out !== ((i % 5) < 2)) begin n_fail++; $display("FAIL div5 clk_out i=%0d: got %b want %b", i, clk_out, (i % 5) < 2); end
      step();
    end
    go_idle();
  endtask

  // Load while running: applied at the boundary, last pending value wins,
  // and a load on the boundary edge waits for the next boundary.
  task automatic test_run_load();
    div_in = 16'd4; div_load = 1'b1;
    step();
    div_load = 1'b0; start = 1'b1;
    step();                                   // cnt=0, N=4
    step();                                   // cnt=1
    div_in = 16'd7; div_load = 1'b1;
    step();                                   // cnt=2, pending=7
    div_load = 1'b0;
    n_checks++; if (div_cur !== 16'd4) begin n_fail++; $display("FAIL run_load early div_cur: got %0d want 4", div_cur); end
    step();                                   // cnt=3
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL run_load old tick: got %b want 1", tick); end
    step();                                   // boundary: cnt=0, N=7
    for (int i = 0; i < 14; i++) begin
      n_checks++; if (div_cur !== 16'd7) begin n_fail++; $display("FAIL run_load div_cur i=%0d: got %0d want 7", i, div_cur); end
      n_checks++; if (load_ack !== (i == 0)) begin n_fail++; $display("FAIL run_load ack i=%0d: got %b want %b", i, load_ack, i == 0); end
      n_checks++; if (tick !== ((i % 7) == 6)) begin n_fail++; $display("FAIL div7 tick i=%0d: got %b want %b", i, tick, (i % 7) == 6); end
      n_checks++; if (clk_out !== ((i % 7) < 3)) begin n_fail++; $display("FAIL div7 clk_out i=%0d: got %b want %b", i, clk_out, (i % 7) < 3); end
      step();
    end
    // cnt=0 here: stage 3, then load 5 exactly on the boundary edge.
    div_in = 16'd3; div_load = 1'b1;
    step();                                   // cnt=1
    div_load = 1'b0;
    repeat (5) step();                        // cnt=6
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL b2b tick at 6: got %b want 1", tick); end
    div_in = 16'd5; div_load = 1'b1;
    step();                                   // boundary: N=3, pending=5
    div_load = 1'b0;
    n_checks++; if (div_cur !== 16'd3) begin n_fail++; $display("FAIL b2b div_cur: got %0d want 3", div_cur); end
    n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL b2b ack1: got %b want 1", load_ack); end
    step();                                   // cnt=1
    n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL b2b ack1 drop: got %b want 0", load_ack); end
    step();                                   // cnt=2
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL b2b tick at 2: got %b want 1", tick); end
    step();                                   // boundary: N=5
    n_checks++; if (div_cur !== 16'd5) begin n_fail++; $display("FAIL b2b div_cur2: got %0d want 5", div_cur); end
    n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL b2b ack2: got %b want 1", load_ack); end
    go_idle();
  endtask

  // Clamp of 0/1 and a load on the IDLE->RUN edge.
  task automatic test_clamp();
    div_in = 16'd0; div_load = 1'b1;
    step();
    n_checks++; if (div_cur !== 16'd2) begin n_fail++; $display("FAIL clamp0 div_cur: got %0d want 2", div_cur); end
    div_in = 16'd9;
    step();
    n_checks++; if (div_cur !== 16'd9) begin n_fail++; $display("FAIL clamp load9 div_cur: got %0d want 9", div_cur); end
    div_in = 16'd1;
    step();
    n_checks++; if (div_cur !== 16'd2) begin n_fail++; $display("FAIL clamp1 div_cur: got %0d want 2", div_cur); end
    div_in = 16'd3; start = 1'b1;
    step();                                   // RUN, cnt=0, N=3
    div_load = 1'b0;
    n_checks++; if (div_cur !== 16'd3) begin n_fail++; $display("FAIL start_load div_cur: got %0d want 3", div_cur); end
    n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL start_load ack: got %b want 1", load_ack); end
    step();                                   // cnt=1
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL start_load tick1: got %b want 0", tick); end
    step();                                   // cnt=2
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL start_load tick2: got %b want 1", tick); end
    go_idle();
  endtask

  // Graceful stop, stop on a tick, and STOPPING->RUN resume at N=6.
  task automatic test_stop();
    int extra;
    div_in = 16'd6; div_load = 1'b1;
    step();
    div_load = 1'b0; start = 1'b1;
    step();                                   // cnt=0
    start = 1'b0;
    step();                                   // cnt=1
    stop = 1'b1;
    step();                                   // STOPPING, cnt=2
    stop = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stop busy: got %b want 1", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL stop early tick: got %b want 0", tick); end
    repeat (3) step();                        // cnt=5
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL stop final tick: got %b want 1", tick); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stop busy at 5: got %b want 1", busy); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop idle busy: got %b want 0", busy); end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL stop idle clk_out: got %b want 0", clk_out); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (tick === 1'b1) extra++;
      step();
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL stop no_more_ticks: got %0d want 0", extra); end

    // Stop asserted on the tick cycle: straight to IDLE.
    start = 1'b1;
    step();                                   // cnt=0
    start = 1'b0;
    repeat (5) step();                        // cnt=5
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL stop_on_tick tick: got %b want 1", tick); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_on_tick busy: got %b want 0", busy); end

    // Resume from STOPPING without restarting the count.
    start = 1'b1;
    step();                                   // cnt=0
    start = 1'b0;
    step();                                   // cnt=1
    stop = 1'b1;
    step();                                   // STOPPING, cnt=2
    stop = 1'b0; start = 1'b1;
    step();                                   // RUN, cnt=3
    start = 1'b0;
    step();                                   // cnt=4
    step();                                   // cnt=5
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL resume tick: got %b want 1", tick); end
    step();                                   // still RUN, cnt=0
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resume busy: got %b want 1", busy); end
    n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL resume clk_out: got %b want 1", clk_out); end
    go_idle();
  endtask

  // Reset mid-period with a pending divisor: everything back to defaults.
  task automatic test_reset_mid();
    div_in = 16'd6; div_load = 1'b1;
    step();
    div_load = 1'b0; start = 1'b1;
    step();                                   // cnt=0
    start = 1'b0;
    div_in = 16'd9; div_load = 1'b1;
    step();                                   // cnt=1, pending=9
    div_load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid tick: got %b want 0", tick); end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid clk_out: got %b want 0", clk_out); end
    n_checks++; if (div_cur !== 16'd2) begin n_fail++; $display("FAIL rst_mid div_cur: got %0d want 2", div_cur); end
    start = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (tick !== ((i % 2) == 1)) begin n_fail++; $display("FAIL rst_mid tick i=%0d: got %b want %b", i, tick, (i % 2) == 1); end
      n_checks++; if (div_cur !== 16'd2) begin n_fail++; $display("FAIL rst_mid pend leak i=%0d: got %0d want 2", i, div_cur); end
      n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid ack i=%0d: got %b want 0", i, load_ack); end
      step();
    end
    go_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_load = 1'b0; div_in = '0;
    test_reset();
    test_default_div();
    test_idle_load();
    test_run_load();
    test_clamp();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
